// File: rtl/axis_hex_string_to_axis_packet.sv
// axis_hex_string_to_axis_packet: parses ASCII hex field lines into AXI-Stream data words
module axis_hex_string_to_axis_packet #(
  parameter int MBUS_WIDTH = 2,
  parameter int USER_WIDTH = 4,
  parameter int DEST_WIDTH = 4,
  parameter logic [7:0] DELIMITER = ";",
  parameter logic [7:0] TERMINATION = "\n",
  parameter logic [7:0] DATA_PREFIX = "#",
  parameter logic [7:0] DEST_PREFIX = "&",
  parameter logic [7:0] USER_PREFIX = "*"
) (
  input  logic                    aclk,
  input  logic                    arstn,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [MBUS_WIDTH*8-1:0] m_axis_tdata,
  output logic [MBUS_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    parse_error,
  output logic [7:0]              error_count
);
  localparam int DW = MBUS_WIDTH * 8;
  localparam int DATA_MAX = 2 * MBUS_WIDTH;
  localparam int DEST_MAX = (DEST_WIDTH + 3) / 4;
  localparam int USER_MAX = (USER_WIDTH + 3) / 4;
  localparam int MAXD = DATA_MAX > DEST_MAX ? (DATA_MAX > USER_MAX ? DATA_MAX : USER_MAX)
                                            : (DEST_MAX > USER_MAX ? DEST_MAX : USER_MAX);
  localparam int AW = 4 * MAXD;
  localparam int CW = $clog2(MAXD + 1);

  typedef enum logic [2:0] {IDLE, DATA, DEST, USER, SKIP, FLUSH} state_t;

  state_t                  state;
  logic [AW-1:0]           acc;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           lim;
  logic [DEST_WIDTH-1:0]   dest_reg;
  logic [USER_WIDTH-1:0]   user_reg;
  logic                    pend_valid;
  logic [DW-1:0]           pend_data;
  logic [MBUS_WIDTH-1:0]   pend_keep;
  logic [USER_WIDTH-1:0]   pend_user;
  logic [DEST_WIDTH-1:0]   pend_dest;
  logic [MBUS_WIDTH-1:0]   keep_new;
  logic [3:0]              nib;
  logic                    is_hex, is_delim, is_term, is_pfx, field, accept, out_free, err, push, push_last;

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = arstn && out_free && state != FLUSH;
  assign accept = s_axis_tvalid && s_axis_tready;
  assign is_delim = s_axis_tdata == DELIMITER;
  assign is_term = s_axis_tdata == TERMINATION;
  assign is_pfx = s_axis_tdata == DATA_PREFIX || s_axis_tdata == DEST_PREFIX || s_axis_tdata == USER_PREFIX;
  assign field = state == DATA || state == DEST || state == USER;
  assign lim = state == DATA ? CW'(DATA_MAX) : state == DEST ? CW'(DEST_MAX) : CW'(USER_MAX);
  assign err = accept && (state == IDLE ? !(is_pfx || is_delim || is_term)
                        : field && ((is_delim || is_term) ? cnt == '0 : (!is_hex || cnt == lim)));
  // a word leaves when a line ends, or when a newer data word displaces the pending one
  assign push = state == FLUSH ? out_free
              : accept && !err && ((is_term && (pend_valid || state == DATA)) || (is_delim && state == DATA && pend_valid));
  assign push_last = state == FLUSH || (is_term && !(state == DATA && pend_valid));

  // hex digit decode of the incoming character
  always_comb begin
    is_hex = 1'b1;
    nib = 4'd0;
    if (s_axis_tdata >= 8'h30 && s_axis_tdata <= 8'h39) nib = 4'(s_axis_tdata - 8'h30);
    else if (s_axis_tdata >= 8'h41 && s_axis_tdata <= 8'h46) nib = 4'(s_axis_tdata - 8'h37);
    else if (s_axis_tdata >= 8'h61 && s_axis_tdata <= 8'h66) nib = 4'(s_axis_tdata - 8'h57);
    else is_hex = 1'b0;
  end

  // one keep bit per byte covered by the received digits
  always_comb begin
    keep_new = '0;
    for (int i = 0; i < MBUS_WIDTH; i++) keep_new[i] = i < (int'(cnt) + 1) / 2;
  end

  // output register: loads on push, otherwise drains on handshake
  always_ff @(posedge aclk or negedge arstn)
    if (!arstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= '0;
      m_axis_tdest <= '0;
    end else if (push) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata <= pend_valid ? pend_data : DW'(acc);
      m_axis_tkeep <= pend_valid ? pend_keep : keep_new;
      m_axis_tlast <= push_last;
      m_axis_tuser <= pend_valid ? pend_user : user_reg;
      m_axis_tdest <= pend_valid ? pend_dest : dest_reg;
    end else if (m_axis_tready) m_axis_tvalid <= 1'b0;

  // line parser FSM with field accumulator, tag registers and pending word
  always_ff @(posedge aclk or negedge arstn)
    if (!arstn) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      dest_reg <= '0;
      user_reg <= '0;
      pend_valid <= 1'b0;
      pend_data <= '0;
      pend_keep <= '0;
      pend_user <= '0;
      pend_dest <= '0;
      parse_error <= 1'b0;
      error_count <= '0;
    end else begin
      parse_error <= 1'b0;
      if (state == FLUSH) begin
        if (out_free) begin
          pend_valid <= 1'b0;
          state <= IDLE;
        end
      end else if (accept) begin
        if (err) begin
          parse_error <= 1'b1;
          error_count <= error_count + 8'(error_count != 8'hFF);
          state <= SKIP;
        end else if (!field) begin
          if (is_term) begin
            pend_valid <= 1'b0;
            state <= IDLE;
          end else if (state == IDLE && is_pfx) begin
            acc <= '0;
            cnt <= '0;
            state <= s_axis_tdata == DATA_PREFIX ? DATA : s_axis_tdata == DEST_PREFIX ? DEST : USER;
          end
        end else if (is_delim || is_term) begin
          state <= is_term && state == DATA && pend_valid ? FLUSH : IDLE;
          if (state == DEST) dest_reg <= DEST_WIDTH'(acc);
          if (state == USER) user_reg <= USER_WIDTH'(acc);
          if (state == DATA && (is_delim || pend_valid)) begin
            pend_valid <= 1'b1;
            pend_data <= DW'(acc);
            pend_keep <= keep_new;
            pend_user <= user_reg;
            pend_dest <= dest_reg;
          end else if (is_term) pend_valid <= 1'b0;
        end else begin
          acc <= AW'({acc, nib});
          cnt <= cnt + 1'b1;
        end
      end
    end
endmodule
